// File: rtl/clk_div_track_pkg.sv
// Shared state encoding and default sizing for the divided-clock edge tracker.
package clk_div_track_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_LOCK_COUNT = 2;

   localparam logic [1:0] ENC_IDLE    = 2'b00;
   localparam logic [1:0] ENC_ACQUIRE = 2'b01;
   localparam logic [1:0] ENC_MEASURE = 2'b10;
   localparam logic [1:0] ENC_LOCKED  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = ENC_IDLE,
      ACQUIRE = ENC_ACQUIRE,
      MEASURE = ENC_MEASURE,
      LOCKED  = ENC_LOCKED
   } state_t;

endpackage

// File: rtl/clock_div_edge_tracker_if.sv
// Divided-clock observation bus: master drives the divided clock and gate, slave reports tracking.
interface clock_div_edge_tracker_if #(
   parameter int width = clk_div_track_pkg::DEF_WIDTH
);

   logic             DIV_IN;
   logic             GATE_IN;
   logic             PREEDGE;
   logic             LOCKED;
   logic             ERROR;
   logic [width-1:0] PERIOD;
   logic [width-1:0] HIGH_CNT;

   modport master (
      output DIV_IN, GATE_IN,
      input  PREEDGE, LOCKED, ERROR, PERIOD, HIGH_CNT
   );

   modport slave (
      input  DIV_IN, GATE_IN,
      output PREEDGE, LOCKED, ERROR, PERIOD, HIGH_CNT
   );

endinterface

// File: rtl/clk_div_period_meas.sv
// Rise detection and phase/high-time counters for the sampled divided clock.
// High-time counter exists only when CLK_DIV_TRACK_DUTY_EN is defined.
module clk_div_period_meas #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_in,
   output logic             rise,
   output logic             timeout,
   output logic [width-1:0] ph,
   output logic [width-1:0] meas_period
`ifdef CLK_DIV_TRACK_DUTY_EN
   ,
   output logic [width-1:0] hi
`endif
);

   localparam logic [width-1:0] ALL_ONES = '1;
   localparam logic [width-1:0] W_ONE    = width'(1);

   logic d_q;

   assign rise        = div_in & ~d_q;
   assign timeout     = (ph == ALL_ONES) & ~rise;
   // ph holds at all-ones, so the captured period saturates instead of wrapping.
   assign meas_period = (ph == ALL_ONES) ? ALL_ONES : ph + W_ONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= 1'b0;
         ph  <= '0;
      end else begin
         d_q <= div_in;
         if (rise)
            ph <= '0;
         else if (ph != ALL_ONES)
            ph <= ph + W_ONE;
      end
   end

`ifdef CLK_DIV_TRACK_DUTY_EN
   // The rise cycle itself is high, so a new high interval starts at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hi <= '0;
      else if (rise)
         hi <= W_ONE;
      else if (div_in && (hi != ALL_ONES))
         hi <= hi + W_ONE;
   end
`endif

endmodule

// File: rtl/clock_div_edge_tracker.sv
// Fast-domain tracker for a divided, gated clock: measures period, locks, predicts rises.
// Define CLK_DIV_TRACK_DUTY_EN to also track high time and require it to match for lock.
module clock_div_edge_tracker
   import clk_div_track_pkg::*;
#(
   parameter int width      = DEF_WIDTH,
   parameter int lock_count = DEF_LOCK_COUNT
) (
   input  logic                   CLK,
   input  logic                   RST,
   clock_div_edge_tracker_if.slave bus,
   output state_t                 dbg_state
);

   localparam int MW = $clog2(lock_count + 1);
   localparam logic [MW-1:0]    M_ONE  = MW'(1);
   localparam logic [MW-1:0]    M_LOCK = MW'(lock_count);
   localparam logic [width-1:0] W_ONE  = width'(1);

   logic             rise;
   logic             timeout;
   logic [width-1:0] ph;
   logic [width-1:0] meas_period;
   state_t           state;
   logic [MW-1:0]    match;
   logic [MW-1:0]    match_nxt;
   logic             same;
   logic             locked_q;
   logic             error_q;
   logic [width-1:0] period_q;

`ifdef CLK_DIV_TRACK_DUTY_EN
   logic [width-1:0] hi;
   logic [width-1:0] high_q;

   clk_div_period_meas #(.width(width)) u_meas (
      .clk(CLK), .rst_n(RST), .div_in(bus.DIV_IN), .rise(rise), .timeout(timeout),
      .ph(ph), .meas_period(meas_period), .hi(hi)
   );

   assign same         = (meas_period == period_q) && (hi == high_q);
   assign bus.HIGH_CNT = high_q;
`else
   clk_div_period_meas #(.width(width)) u_meas (
      .clk(CLK), .rst_n(RST), .div_in(bus.DIV_IN), .rise(rise), .timeout(timeout),
      .ph(ph), .meas_period(meas_period)
   );

   assign same         = (meas_period == period_q);
   assign bus.HIGH_CNT = '0;
`endif

   // match==0 means no period captured yet in this acquisition, so nothing to compare against.
   assign match_nxt = ((match != '0) && same) ? match + M_ONE : M_ONE;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         match    <= '0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
         period_q <= '0;
`ifdef CLK_DIV_TRACK_DUTY_EN
         high_q   <= '0;
`endif
      end else begin
         error_q <= 1'b0;
         if (!bus.GATE_IN) begin
            state    <= IDLE;
            locked_q <= 1'b0;
            match    <= '0;
         end else begin
            case (state)
               IDLE: state <= ACQUIRE;
               ACQUIRE: begin
                  if (rise) begin
                     state <= MEASURE;
                     match <= '0;
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     period_q <= meas_period;
`ifdef CLK_DIV_TRACK_DUTY_EN
                     high_q   <= hi;
`endif
                     match    <= match_nxt;
                     if (match_nxt == M_LOCK) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else if (timeout) begin
                     state <= ACQUIRE;
                  end
               end
               LOCKED: begin
                  if (rise) begin
                     period_q <= meas_period;
`ifdef CLK_DIV_TRACK_DUTY_EN
                     high_q   <= hi;
`endif
                     if (!same) begin
                        error_q  <= 1'b1;
                        state    <= MEASURE;
                        locked_q <= 1'b0;
                        match    <= M_ONE;
                     end
                  end else if (timeout) begin
                     error_q  <= 1'b1;
                     state    <= ACQUIRE;
                     locked_q <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.LOCKED  = locked_q;
   assign bus.ERROR   = error_q;
   assign bus.PERIOD  = period_q;
   assign bus.PREEDGE = locked_q & (ph == period_q - W_ONE);
   assign dbg_state   = state;

endmodule

// File: tb/tb_clock_div_edge_tracker.sv
// Directed bench for clock_div_edge_tracker: cycle table for lock/relock plus hand sequences.
module tb_clock_div_edge_tracker;
   import clk_div_track_pkg::*;

   localparam int W  = 4;
   localparam int NV = 29;
`ifdef CLK_DIV_TRACK_DUTY_EN
   localparam int DUTY = 1;
   localparam int HI2  = 2;
   localparam int HI1  = 1;
`else
   localparam int DUTY = 0;
   localparam int HI2  = 0;
   localparam int HI1  = 0;
`endif

   typedef struct {
      logic         div;
      logic         locked;
      logic         pre;
      logic         err;
      logic [W-1:0] per;
      logic [W-1:0] hc;
   } vec_t;

   vec_t           vecs[NV];
   logic [2+2*W:0] exp_q[$];
   int             total = 0;
   int             bad   = 0;
   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   state_t         dbg_state;

   clock_div_edge_tracker_if #(.width(W)) bus();

   clock_div_edge_tracker #(.width(W), .lock_count(2)) dut (
      .CLK(clk), .RST(rst_n), .bus(bus), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic vec_t v(int d, int l, int p, int e, int per, int hc);
      vec_t r;
      r.div = 1'(d); r.locked = 1'(l); r.pre = 1'(p); r.err = 1'(e);
      r.per = W'(per); r.hc = W'(hc);
      return r;
   endfunction

   // driver: inputs change on negedge, outputs sampled 1ns after the posedge
   task automatic cyc(input logic d, input logic g);
      @(negedge clk);
      bus.DIV_IN  = d;
      bus.GATE_IN = g;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] l, input logic [31:0] p,
                          input logic [31:0] e, input logic [31:0] per, input logic [31:0] hc);
      chk({tag, "_locked"}, 32'(bus.LOCKED), l);
      chk({tag, "_preedge"}, 32'(bus.PREEDGE), p);
      chk({tag, "_error"}, 32'(bus.ERROR), e);
      chk({tag, "_period"}, 32'(bus.PERIOD), per);
      chk({tag, "_high"}, 32'(bus.HIGH_CNT), hc);
   endtask

   task automatic chk_state(input string tag, input state_t want);
      chk({tag, "_state"}, 32'(dbg_state), 32'(want));
   endtask

   initial begin
      logic [2+2*W:0] e;

      // lock on 0,1,1 (period 3), then switch to 0,0,0,1,1 (period 5) and relock
      vecs[0]  = v(0, 0,0,0, 0,0);
      vecs[1]  = v(1, 0,0,0, 0,0);
      vecs[2]  = v(1, 0,0,0, 0,0);
      vecs[3]  = v(0, 0,0,0, 0,0);
      vecs[4]  = v(1, 0,0,0, 3,HI2);
      vecs[5]  = v(1, 0,0,0, 3,HI2);
      vecs[6]  = v(0, 0,0,0, 3,HI2);
      vecs[7]  = v(1, 1,0,0, 3,HI2);
      vecs[8]  = v(1, 1,0,0, 3,HI2);
      vecs[9]  = v(0, 1,1,0, 3,HI2);
      vecs[10] = v(1, 1,0,0, 3,HI2);
      vecs[11] = v(1, 1,0,0, 3,HI2);
      vecs[12] = v(0, 1,1,0, 3,HI2);
      vecs[13] = v(1, 1,0,0, 3,HI2);
      vecs[14] = v(1, 1,0,0, 3,HI2);
      vecs[15] = v(0, 1,1,0, 3,HI2);
      vecs[16] = v(0, 1,0,0, 3,HI2);
      vecs[17] = v(0, 1,0,0, 3,HI2);
      vecs[18] = v(1, 0,0,1, 5,HI2);
      vecs[19] = v(1, 0,0,0, 5,HI2);
      vecs[20] = v(0, 0,0,0, 5,HI2);
      vecs[21] = v(0, 0,0,0, 5,HI2);
      vecs[22] = v(0, 0,0,0, 5,HI2);
      vecs[23] = v(1, 1,0,0, 5,HI2);
      vecs[24] = v(1, 1,0,0, 5,HI2);
      vecs[25] = v(0, 1,0,0, 5,HI2);
      vecs[26] = v(0, 1,0,0, 5,HI2);
      vecs[27] = v(0, 1,1,0, 5,HI2);
      vecs[28] = v(1, 1,0,0, 5,HI2);
      foreach (vecs[i])
         exp_q.push_back({vecs[i].locked, vecs[i].pre, vecs[i].err, vecs[i].per, vecs[i].hc});

      bus.DIV_IN  = 1'b0;
      bus.GATE_IN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 0, 0, 0, 0, 0);
      chk_state("reset", IDLE);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cyc(vecs[i].div, 1'b1);
         e = exp_q.pop_front();
         chk_out($sformatf("vec%0d", i), 32'(e[2+2*W]), 32'(e[1+2*W]), 32'(e[2*W]),
                 32'(e[2*W-1:W]), 32'(e[W-1:0]));
      end

      // locked at 5, one period of 3 -> error, next period of 3 -> relock
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      chk_out("a_err53", 0, 0, 1, 3, HI2);
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      chk_out("a_relock3", 1, 0, 0, 3, HI2);
      cyc(1, 1); cyc(0, 1);
      chk_out("a_pre", 1, 1, 0, 3, HI2);
      // gate falls in the same cycle as a rise: gate wins, no error
      cyc(1, 0);
      chk_out("gate_off", 0, 0, 0, 3, HI2);
      chk_state("gate_off", IDLE);
      cyc(0, 0);
      chk_state("gate_hold", IDLE);

      // reacquire, then hold DIV_IN low until the phase counter times out
      cyc(0, 1);
      chk_state("b_acq", ACQUIRE);
      cyc(1, 1);
      chk_state("b_meas", MEASURE);
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      chk_out("b_lock", 1, 0, 0, 3, HI2);
      for (int k = 0; k < 15; k++) cyc(0, 1);
      chk_out("b_pre_to", 1, 0, 0, 3, HI2);
      cyc(0, 1);
      chk_out("b_timeout", 0, 0, 1, 3, HI2);
      chk_state("b_timeout", ACQUIRE);
      cyc(0, 1);
      chk_out("b_after", 0, 0, 0, 3, HI2);
      chk_state("b_after", ACQUIRE);

      // lock on 0,1,1 then change only the duty cycle to 0,0,1
      cyc(1, 1);
      chk_state("c_meas", MEASURE);
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      cyc(1, 1); cyc(0, 1); cyc(1, 1);
      chk_out("c_lock", 1, 0, 0, 3, HI2);
      cyc(0, 1); cyc(0, 1);
      chk_out("c_pre", 1, 1, 0, 3, HI2);
      cyc(1, 1);
      chk_out("c_duty", 1 - DUTY, 0, DUTY, 3, HI1);
      cyc(0, 1); cyc(0, 1); cyc(1, 1);
      chk_out("c_relock", 1, 0, 0, 3, HI1);
      cyc(0, 1); cyc(0, 1);
      chk_out("c_pre2", 1, 1, 0, 3, HI1);

      // asynchronous reset mid-cycle while PREEDGE is high
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("rst_mid", 0, 0, 0, 0, 0);
      chk_state("rst_mid", IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1);
      chk_out("rst_after", 0, 0, 0, 0, 0);
      chk_state("rst_after", ACQUIRE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
